// File: rtl/fu_execute_bank.sv
// Three-slot execute bank: ALU ops broadcast one cycle after issue; loads/stores share a
// single round-robin arbitrated memory port with at most one transaction in flight.
module fu_execute_bank #(
    parameter int unsigned AR_SIZE  = 6,
    parameter int unsigned FU_ARRAY = 3,
    parameter int unsigned XLEN     = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [FU_ARRAY-1:0]         tunnel_in,
    input  logic [4*FU_ARRAY-1:0]       op_in,
    input  logic [AR_SIZE*FU_ARRAY-1:0] rd_in,
    input  logic [XLEN*FU_ARRAY-1:0]    rs1_value_in,
    input  logic [XLEN*FU_ARRAY-1:0]    rs2_value_in,
    input  logic [XLEN*FU_ARRAY-1:0]    imm_value_in,
    output logic [FU_ARRAY-1:0]         fu_ready_out,
    output logic                        FU0_flag_out,
    output logic                        FU1_flag_out,
    output logic                        FU2_flag_out,
    output logic [AR_SIZE-1:0]          reg_tag_from_FU0_out,
    output logic [AR_SIZE-1:0]          reg_tag_from_FU1_out,
    output logic [AR_SIZE-1:0]          reg_tag_from_FU2_out,
    output logic [XLEN-1:0]             reg_value_from_FU0_out,
    output logic [XLEN-1:0]             reg_value_from_FU1_out,
    output logic [XLEN-1:0]             reg_value_from_FU2_out,
    output logic                        mem_req_out,
    output logic                        mem_we_out,
    output logic [XLEN-1:0]             mem_addr_out,
    output logic [XLEN-1:0]             mem_wdata_out,
    output logic [3:0]                  mem_be_out,
    input  logic                        mem_gnt_in,
    input  logic                        mem_rvalid_in,
    input  logic [XLEN-1:0]             mem_rdata_in,
    output logic                        issue_err_out
);

    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpAddi = 4'd2;
    localparam logic [3:0] OpLui  = 4'd3;
    localparam logic [3:0] OpOri  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSrai = 4'd6;
    localparam logic [3:0] OpLb   = 4'd7;
    localparam logic [3:0] OpLw   = 4'd8;
    localparam logic [3:0] OpSb   = 4'd9;
    localparam logic [3:0] OpSw   = 4'd10;

    typedef enum logic [1:0] {StIdle, StBcast, StMemReq, StMemWait} slot_st_e;

    slot_st_e            st_q   [FU_ARRAY];
    logic [3:0]          op_q   [FU_ARRAY];
    logic [AR_SIZE-1:0]  rd_q   [FU_ARRAY];
    logic [XLEN-1:0]     addr_q [FU_ARRAY];
    logic [XLEN-1:0]     sdata_q[FU_ARRAY];
    logic [FU_ARRAY-1:0] flag_q;
    logic [AR_SIZE-1:0]  tag_q  [FU_ARRAY];
    logic [XLEN-1:0]     val_q  [FU_ARRAY];

    logic [3:0]          op_s   [FU_ARRAY];
    logic [XLEN-1:0]     rs1_s  [FU_ARRAY];
    logic [XLEN-1:0]     rs2_s  [FU_ARRAY];
    logic [XLEN-1:0]     imm_s  [FU_ARRAY];
    logic [AR_SIZE-1:0]  rd_s   [FU_ARRAY];
    logic [XLEN-1:0]     alu_res[FU_ARRAY];
    logic [XLEN-1:0]     ld_val [FU_ARRAY];
    logic [FU_ARRAY-1:0] accept;
    logic [FU_ARRAY-1:0] is_alu;
    logic [FU_ARRAY-1:0] is_mem;

    logic [1:0] ptr_q;
    logic [1:0] mem_slot_q;
    logic [1:0] arb_idx;
    logic [2:0] cand;
    logic       arb_valid;
    logic       any_wait;
    logic       launch;
    logic [7:0] ld_byte;

    always_comb begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            op_s[i]   = op_in[4*i +: 4];
            rd_s[i]   = rd_in[AR_SIZE*i +: AR_SIZE];
            rs1_s[i]  = rs1_value_in[XLEN*i +: XLEN];
            rs2_s[i]  = rs2_value_in[XLEN*i +: XLEN];
            imm_s[i]  = imm_value_in[XLEN*i +: XLEN];
            accept[i] = tunnel_in[i] & fu_ready_out[i];
            is_alu[i] = (op_s[i] >= OpAdd) && (op_s[i] <= OpSrai);
            is_mem[i] = (op_s[i] >= OpLb) && (op_s[i] <= OpSw);
            case (op_s[i])
                OpAdd:   alu_res[i] = rs1_s[i] + rs2_s[i];
                OpAddi:  alu_res[i] = rs1_s[i] + imm_s[i];
                OpLui:   alu_res[i] = imm_s[i];
                OpOri:   alu_res[i] = rs1_s[i] | imm_s[i];
                OpXor:   alu_res[i] = rs1_s[i] ^ imm_s[i];
                OpSrai:  alu_res[i] = XLEN'($signed(rs1_s[i]) >>> imm_s[i][4:0]);
                default: alu_res[i] = '0;
            endcase
            ld_byte   = mem_rdata_in[{addr_q[i][1:0], 3'b000} +: 8];
            ld_val[i] = (op_q[i] == OpLb) ? {{(XLEN-8){ld_byte[7]}}, ld_byte} : mem_rdata_in;
        end
    end

    // Round-robin search starting at ptr_q; new requests wait while a load is outstanding.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        any_wait  = 1'b0;
        cand      = '0;
        for (int k = 0; k < FU_ARRAY; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'(FU_ARRAY)) cand = cand - 3'(FU_ARRAY);
            if (!arb_valid && st_q[cand[1:0]] == StMemReq) begin
                arb_valid = 1'b1;
                arb_idx   = cand[1:0];
            end
            if (st_q[k] == StMemWait) any_wait = 1'b1;
        end
        launch = !mem_req_out && arb_valid && !any_wait;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                st_q[i]    <= StIdle;
                op_q[i]    <= '0;
                rd_q[i]    <= '0;
                addr_q[i]  <= '0;
                sdata_q[i] <= '0;
                tag_q[i]   <= '0;
                val_q[i]   <= '0;
            end
            flag_q        <= '0;
            fu_ready_out  <= '1;
            issue_err_out <= 1'b0;
        end else begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                flag_q[i] <= 1'b0;
                if (tunnel_in[i] && !fu_ready_out[i]) issue_err_out <= 1'b1;
                unique case (st_q[i])
                    StIdle, StBcast: begin
                        st_q[i] <= StIdle;
                        if (accept[i]) begin
                            op_q[i]    <= op_s[i];
                            rd_q[i]    <= rd_s[i];
                            addr_q[i]  <= rs1_s[i] + imm_s[i];
                            sdata_q[i] <= rs2_s[i];
                            if (is_alu[i]) begin
                                st_q[i]   <= StBcast;
                                flag_q[i] <= 1'b1;
                                tag_q[i]  <= rd_s[i];
                                val_q[i]  <= alu_res[i];
                            end else if (is_mem[i]) begin
                                st_q[i]         <= StMemReq;
                                fu_ready_out[i] <= 1'b0;
                            end
                        end
                    end
                    StMemReq: begin
                        if (mem_req_out && mem_gnt_in && mem_slot_q == 2'(i)) begin
                            if (op_q[i] == OpSb || op_q[i] == OpSw) begin
                                st_q[i]         <= StIdle;
                                fu_ready_out[i] <= 1'b1;
                            end else begin
                                st_q[i] <= StMemWait;
                            end
                        end
                    end
                    StMemWait: begin
                        if (mem_rvalid_in && mem_slot_q == 2'(i)) begin
                            st_q[i]         <= StBcast;
                            fu_ready_out[i] <= 1'b1;
                            flag_q[i]       <= 1'b1;
                            tag_q[i]        <= rd_q[i];
                            val_q[i]        <= ld_val[i];
                        end
                    end
                    default: st_q[i] <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_be_out    <= '0;
            mem_slot_q    <= '0;
            ptr_q         <= '0;
        end else if (mem_req_out) begin
            if (mem_gnt_in) begin
                mem_req_out <= 1'b0;
                ptr_q       <= (mem_slot_q == 2'(FU_ARRAY-1)) ? 2'd0 : mem_slot_q + 2'd1;
            end
        end else if (launch) begin
            mem_req_out  <= 1'b1;
            mem_slot_q   <= arb_idx;
            mem_addr_out <= addr_q[arb_idx];
            mem_we_out   <= (op_q[arb_idx] == OpSb) || (op_q[arb_idx] == OpSw);
            case (op_q[arb_idx])
                OpSw: begin
                    mem_be_out    <= 4'b1111;
                    mem_wdata_out <= sdata_q[arb_idx];
                end
                OpSb: begin
                    mem_be_out    <= 4'b0001 << addr_q[arb_idx][1:0];
                    mem_wdata_out <= {(XLEN/8){sdata_q[arb_idx][7:0]}};
                end
                OpLb: begin
                    mem_be_out    <= 4'b0001 << addr_q[arb_idx][1:0];
                    mem_wdata_out <= '0;
                end
                default: begin
                    mem_be_out    <= 4'b1111;
                    mem_wdata_out <= '0;
                end
            endcase
        end
    end

    assign FU0_flag_out           = flag_q[0];
    assign FU1_flag_out           = flag_q[1];
    assign FU2_flag_out           = flag_q[2];
    assign reg_tag_from_FU0_out   = tag_q[0];
    assign reg_tag_from_FU1_out   = tag_q[1];
    assign reg_tag_from_FU2_out   = tag_q[2];
    assign reg_value_from_FU0_out = val_q[0];
    assign reg_value_from_FU1_out = val_q[1];
    assign reg_value_from_FU2_out = val_q[2];

endmodule

// File: tb/tb_fu_execute_bank.sv
// Bench for fu_execute_bank: ALU vector table, randomized ALU traffic against an
// arithmetic model, and hand-written memory/reset sequences.
module tb_fu_execute_bank;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  tunnel_in;
    logic [11:0] op_in;
    logic [17:0] rd_in;
    logic [95:0] rs1_value_in, rs2_value_in, imm_value_in;
    logic [2:0]  fu_ready_out;
    logic        f0, f1, f2;
    logic [5:0]  t0, t1, t2;
    logic [31:0] v0, v1, v2;
    logic        mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        mem_gnt_in, mem_rvalid_in;
    logic [31:0] mem_rdata_in;
    logic        issue_err_out;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0]  flags;
    logic [5:0]  tags[3];
    logic [31:0] vals[3];

    always #5 clk = ~clk;

    fu_execute_bank dut (
        .clk(clk), .rstn(rstn), .tunnel_in(tunnel_in), .op_in(op_in), .rd_in(rd_in),
        .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
        .imm_value_in(imm_value_in), .fu_ready_out(fu_ready_out),
        .FU0_flag_out(f0), .FU1_flag_out(f1), .FU2_flag_out(f2),
        .reg_tag_from_FU0_out(t0), .reg_tag_from_FU1_out(t1), .reg_tag_from_FU2_out(t2),
        .reg_value_from_FU0_out(v0), .reg_value_from_FU1_out(v1),
        .reg_value_from_FU2_out(v2), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out), .mem_be_out(mem_be_out),
        .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
        .issue_err_out(issue_err_out)
    );

    always_comb begin
        flags   = {f2, f1, f0};
        tags[0] = t0; tags[1] = t1; tags[2] = t2;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [5:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        logic [31:0] r;
        case (op)
            4'd1: r = a + b;
            4'd2: r = a + imm;
            4'd3: r = imm;
            4'd4: r = a | imm;
            4'd5: r = a ^ imm;
            4'd6: begin
                r = a;
                for (int n = 0; n < int'(imm[4:0]); n++) r = {a[31], r[31:1]};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [3:0] op, input logic [5:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        tunnel_in[s]            = 1'b1;
        op_in[4*s +: 4]         = op;
        rd_in[6*s +: 6]         = rd;
        rs1_value_in[32*s +: 32] = a;
        rs2_value_in[32*s +: 32] = b;
        imm_value_in[32*s +: 32] = imm;
    endtask

    task automatic wait_req(input string name);
        int c;
        c = 0;
        while (!mem_req_out && c < 20) begin
            tick();
            c++;
        end
        chk({name, " req"}, 32'(mem_req_out), 32'd1);
    endtask

    // Serves one request: hold one cycle, grant, and for loads return rdata two cycles later.
    task automatic mem_serve(input string name, input logic [31:0] exp_addr, input logic exp_we,
                             input logic chk_pay, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] rdata);
        wait_req(name);
        if (!mem_req_out) return;
        chk({name, " addr"}, mem_addr_out, exp_addr);
        chk({name, " we"}, 32'(mem_we_out), 32'(exp_we));
        if (chk_pay) begin
            chk({name, " be"}, 32'(mem_be_out), 32'(exp_be));
            chk({name, " wdata"}, mem_wdata_out, exp_wd);
        end
        tick();
        chk({name, " req held"}, 32'(mem_req_out), 32'd1);
        chk({name, " addr held"}, mem_addr_out, exp_addr);
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        if (!exp_we) begin
            tick();
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = rdata;
            tick();
            mem_rvalid_in = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        logic [2:0]  exp_flag;
        logic [5:0]  exp_tag[3];
        logic [31:0] exp_val[3];
        logic [3:0]  rop;
        logic [31:0] ra, rb, ri;
        logic [5:0]  rrd;

        tbl[0] = '{4'd2, 32'd5,          32'd0,  32'd7,          6'd12, 32'd12};
        tbl[1] = '{4'd1, 32'd3,          32'd4,  32'd0,          6'd9,  32'd7};
        tbl[2] = '{4'd6, 32'h80000010,   32'd0,  32'd4,          6'd1,  32'hF8000001};
        tbl[3] = '{4'd3, 32'h0,          32'd0,  32'hABCDE000,   6'd2,  32'hABCDE000};
        tbl[4] = '{4'd4, 32'h0F0F0000,   32'd0,  32'h000000FF,   6'd3,  32'h0F0F00FF};
        tbl[5] = '{4'd5, 32'hFFFF0000,   32'd0,  32'h0F0F0F0F,   6'd4,  32'hF0F00F0F};
        tbl[6] = '{4'd1, 32'hFFFFFFFF,   32'd2,  32'd0,          6'd63, 32'h00000001};
        tbl[7] = '{4'd6, 32'h40000000,   32'd0,  32'h00000025,   6'd5,  32'h02000000};
        tbl[8] = '{4'd2, 32'd10,         32'd0,  32'hFFFFFFFD,   6'd6,  32'd7};
        tbl[9] = '{4'd6, 32'h80000000,   32'd0,  32'd31,         6'd7,  32'hFFFFFFFF};

        rstn = 1'b1;
        tunnel_in = '0; op_in = '0; rd_in = '0;
        rs1_value_in = '0; rs2_value_in = '0; imm_value_in = '0;
        mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = '0;
        #2 rstn = 1'b0;
        tick(); tick();
        @(negedge clk) rstn = 1'b1;
        tick();

        chk("reset ready", 32'(fu_ready_out), 32'h7);
        chk("reset flags", 32'(flags), 32'h0);
        chk("reset req", 32'(mem_req_out), 32'h0);
        chk("reset addr", mem_addr_out, 32'h0);
        chk("reset err", 32'(issue_err_out), 32'h0);
        chk("reset tag0", 32'(t0), 32'h0);
        chk("reset val2", v2, 32'h0);

        // ALU table, slots rotated
        for (int k = 0; k < 10; k++) begin
            s = k % 3;
            set_slot(s, tbl[k].op, tbl[k].rd, tbl[k].a, tbl[k].b, tbl[k].imm);
            tick();
            tunnel_in = '0;
            chk($sformatf("tbl%0d flags", k), 32'(flags), 32'(3'b001 << s));
            chk($sformatf("tbl%0d tag", k), 32'(tags[s]), 32'(tbl[k].rd));
            chk($sformatf("tbl%0d val", k), vals[s], tbl[k].exp);
            tick();
            chk($sformatf("tbl%0d flag drop", k), 32'(flags), 32'h0);
        end

        // SRAI on slot1 alongside ADD on slot2, same broadcast cycle
        set_slot(1, 4'd6, 6'd10, 32'h80000010, 32'd0, 32'd4);
        set_slot(2, 4'd1, 6'd9, 32'd3, 32'd4, 32'd0);
        tick();
        tunnel_in = '0;
        chk("pair flags", 32'(flags), 32'h6);
        chk("pair v1", v1, 32'hF8000001);
        chk("pair v2", v2, 32'd7);
        chk("pair t2", 32'(t2), 32'd9);
        tick();

        // Randomized ALU/NOP traffic, back-to-back issue allowed
        for (int c = 0; c < 200; c++) begin
            exp_flag = '0;
            for (int j = 0; j < 3; j++) begin
                rop = 4'($urandom_range(0, 11));
                if (rop > 4'd6) rop = rop + 4'd4;
                ra = $urandom; rb = $urandom; ri = $urandom; rrd = 6'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    set_slot(j, rop, rrd, ra, rb, ri);
                    if (rop >= 4'd1 && rop <= 4'd6) begin
                        exp_flag[j] = 1'b1;
                        exp_tag[j]  = rrd;
                        exp_val[j]  = model(rop, ra, rb, ri);
                    end
                end else begin
                    tunnel_in[j] = 1'b0;
                end
            end
            tick();
            tunnel_in = '0;
            chk("rnd ready", 32'(fu_ready_out), 32'h7);
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("rnd%0d flag%0d", c, j), 32'(flags[j]), 32'(exp_flag[j]));
                if (exp_flag[j]) begin
                    chk($sformatf("rnd%0d tag%0d", c, j), 32'(tags[j]), 32'(exp_tag[j]));
                    chk($sformatf("rnd%0d val%0d", c, j), vals[j], exp_val[j]);
                end
            end
        end
        tick();

        // Two loads in one cycle: slot0 served first, then slot2
        set_slot(0, 4'd8, 6'd20, 32'h1000, 32'd0, 32'd4);
        set_slot(2, 4'd8, 6'd22, 32'h2000, 32'd0, 32'd8);
        tick();
        tunnel_in = '0;
        chk("lw ready", 32'(fu_ready_out), 32'h2);
        mem_serve("lw0", 32'h1004, 1'b0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);
        chk("lw0 flags", 32'(flags), 32'h1);
        chk("lw0 tag", 32'(t0), 32'd20);
        chk("lw0 val", v0, 32'hDEADBEEF);
        chk("lw0 ready", 32'(fu_ready_out), 32'h3);
        mem_serve("lw2", 32'h2008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h12345678);
        chk("lw2 flags", 32'(flags), 32'h4);
        chk("lw2 tag", 32'(t2), 32'd22);
        chk("lw2 val", v2, 32'h12345678);
        chk("lw2 ready", 32'(fu_ready_out), 32'h7);
        tick();

        // LB sign-extends the byte at addr[1:0]=3
        set_slot(1, 4'd7, 6'd5, 32'h200, 32'd0, 32'd3);
        tick();
        tunnel_in = '0;
        mem_serve("lb", 32'h203, 1'b0, 1'b0, 4'h0, 32'h0, 32'h80FFFFFF);
        chk("lb flags", 32'(flags), 32'h2);
        chk("lb val", v1, 32'hFFFFFF80);
        tick();

        set_slot(0, 4'd9, 6'd7, 32'h100, 32'hAB, 32'd2);
        tick();
        tunnel_in = '0;
        mem_serve("sb", 32'h102, 1'b1, 1'b1, 4'b0100, 32'hABABABAB, 32'h0);
        chk("sb flags", 32'(flags), 32'h0);
        chk("sb ready", 32'(fu_ready_out), 32'h7);
        tick();
        chk("sb no flag", 32'(flags), 32'h0);

        set_slot(2, 4'd10, 6'd8, 32'h300, 32'h11223344, 32'd0);
        tick();
        tunnel_in = '0;
        mem_serve("sw", 32'h300, 1'b1, 1'b1, 4'b1111, 32'h11223344, 32'h0);
        chk("sw flags", 32'(flags), 32'h0);
        tick();

        // Issue to a slot waiting on load data is dropped and flagged
        chk("err clear", 32'(issue_err_out), 32'h0);
        set_slot(0, 4'd8, 6'd30, 32'h400, 32'd0, 32'd0);
        tick();
        tunnel_in = '0;
        wait_req("err lw");
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        set_slot(0, 4'd2, 6'd31, 32'd1, 32'd0, 32'd1);
        tick();
        tunnel_in = '0;
        chk("err set", 32'(issue_err_out), 32'h1);
        chk("err no flag", 32'(flags), 32'h0);
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = 32'hCAFEF00D;
        tick();
        mem_rvalid_in = 1'b0;
        chk("err lw flags", 32'(flags), 32'h1);
        chk("err lw tag", 32'(t0), 32'd30);
        chk("err lw val", v0, 32'hCAFEF00D);
        tick();
        chk("err no extra", 32'(flags), 32'h0);
        chk("err sticky", 32'(issue_err_out), 32'h1);

        // Reset during a load wait aborts it; late rvalid is ignored
        set_slot(1, 4'd8, 6'd40, 32'h500, 32'd0, 32'd0);
        tick();
        tunnel_in = '0;
        wait_req("rst lw");
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        chk("rst pre ready", 32'(fu_ready_out), 32'h5);
        #2 rstn = 1'b0;
        #1;
        chk("rst req", 32'(mem_req_out), 32'h0);
        chk("rst flags", 32'(flags), 32'h0);
        chk("rst ready", 32'(fu_ready_out), 32'h7);
        chk("rst err", 32'(issue_err_out), 32'h0);
        @(negedge clk) rstn = 1'b1;
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = 32'h55555555;
        tick();
        mem_rvalid_in = 1'b0;
        chk("rst late rvalid", 32'(flags), 32'h0);
        tick();
        chk("rst late flags", 32'(flags), 32'h0);
        chk("rst late req", 32'(mem_req_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fu_execute_bank.md
Name: fu_execute_bank

Overview:
- Issue-side counterpart of the unified issue queue: three functional-unit slots receive issued instructions on tunnels 0..2 and execute them.
- Each slot advertises readiness through fu_ready_out and broadcasts results through the FUx_flag/tag/value wakeup ports back to the queue.
- ALU ops complete in one cycle. Loads and stores share a single arbitrated memory port.

Parameters:
- AR_SIZE, 6, physical register tag width
- FU_ARRAY, 3, number of FU slots (fixed at 3)
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- tunnel_in  in  3  bit i=1 issues an instruction to slot i this cycle
- op_in  in  12  4-bit op per slot, slot i at [4i+3:4i]; encoding 1 ADD, 2 ADDI, 3 LUI, 4 ORI, 5 XOR(I), 6 SRAI, 7 LB, 8 LW, 9 SB, 10 SW; others are NOP
- rd_in  in  18  dest tag per slot, 6 bits each
- rs1_value_in  in  96  src1 operand per slot, 32 bits each
- rs2_value_in  in  96  src2 operand per slot
- imm_value_in  in  96  immediate per slot; LUI imm arrives pre-shifted
- fu_ready_out  out  3  slot i can accept an issue this cycle
- FU0_flag_out, FU1_flag_out, FU2_flag_out  out  1 each  result broadcast valid
- reg_tag_from_FU0..2_out  out  6 each  broadcast dest tag
- reg_value_from_FU0..2_out  out  32 each  broadcast value
- mem_req_out  out  1  memory request valid
- mem_we_out  out  1  1 = store
- mem_addr_out  out  32  byte address
- mem_wdata_out  out  32  store data, byte-replicated for SB
- mem_be_out  out  4  byte enables
- mem_gnt_in  in  1  request accepted this cycle
- mem_rvalid_in  in  1  load data valid
- mem_rdata_in  in  32  aligned load word
- issue_err_out  out  1  sticky; set when a tunnel bit arrives while that slot is not ready

Behaviour:
- Reset (async, active-low):
  - all slots IDLE; fu_ready_out=3'b111; all flags 0; tags/values 0.
  - mem_req_out=0, mem_we_out=0, addr/wdata/be 0; issue_err_out=0; arbiter pointer=0.
- Per-slot FSM states: IDLE, BCAST, MEM_REQ, MEM_WAIT.
  - fu_ready_out[i] is registered; it is 1 only in IDLE or BCAST.
  - Accept = tunnel_in[i] & fu_ready_out[i]; operands are latched on the accepting edge.
- ALU ops (1-6): result is computed from the latched operands.
  - Next state BCAST: flag=1, tag=rd, value=result for exactly one cycle.
  - Issue edge N gives flag high in cycle N+1. Back-to-back issue from BCAST is allowed, so throughput is 1/cycle/slot.
  - ADD rs1+rs2; ADDI rs1+imm; LUI imm; ORI rs1|imm; XOR rs1^imm; SRAI rs1>>>imm[4:0]. Arithmetic is mod 2^32 with no overflow flag.
- NOP (0 or 11-15): accepted, no broadcast, slot stays or returns to IDLE.
- Memory ops (7-10): address = rs1+imm; next state MEM_REQ; fu_ready_out=0 until completion.
  - Arbiter: among slots in MEM_REQ, grant round-robin starting at pointer. Pointer moves to granted slot+1 (mod 3) on mem_gnt_in.
  - Only one transaction is in flight. No new mem_req_out while any slot is in MEM_WAIT.
  - mem_req_out and its payload are registered and held stable until mem_gnt_in.
  - Store: be=4'b1111 for SW. For SB, be=1<<addr[1:0] and wdata={4{rs2[7:0]}}. Completes on gnt, then IDLE with no broadcast.
  - Load: on gnt go to MEM_WAIT. On mem_rvalid_in go to BCAST.
  - LW value = rdata. LB = sign-extended byte selected by addr[1:0].
  - Misalignment is not checked; addr[1:0] is passed through.
- Flags of different slots are independent; all three may be high in the same cycle.
- mem_rvalid_in with no slot in MEM_WAIT is ignored.
- Issue to a not-ready slot is dropped, and issue_err_out is set (cleared only by reset).
- Reset asserted mid-transaction aborts everything immediately. Pending rvalid after reset is ignored.

Test Plan:
- ADDI on slot0, rs1=5, imm=7, rd=12 -> FU0_flag=1 one cycle after issue, tag=12, value=12; flag low the next cycle.
- SRAI on slot1, rs1=0x80000010, imm=4; simultaneous ADD on slot2, 3+4, rd=9 -> FU1 value 0xF8000001 and FU2 value 7 in the same cycle.
- LW on slots 0 and 2 in the same cycle, gnt one cycle after req, rvalid two cycles after gnt with 0xDEADBEEF/0x12345678 -> slot0 served first, then slot2; each broadcasts its word; fu_ready stays low until its BCAST.
- LB with addr[1:0]=3, rdata=0x80FFFFFF -> value 0xFFFFFF80. SB with rs2=0xAB at addr 0x102 -> be=4'b0100, wdata=0xABABABAB, no flag.
- Issue to slot0 while it is in MEM_WAIT -> instruction dropped, issue_err_out=1, no extra broadcast.
- rstn pulsed low during MEM_WAIT -> mem_req_out=0, all flags 0, fu_ready_out=3'b111; a late rvalid produces no broadcast.
